board_test_gen: RTL
===================

Name: board_test_gen

Overview:
Parametrised board bring-up pattern generator. A prescaler produces a slow update tick (normal or turbo rate). On each tick, display/GPO/IP registers advance according to one of four button-selected modes. It supports run/pause, single-step and an asynchronous sample of dIn. It sits at the top of the board-test build in place of the CPU, driving the same display outputs.

Parameters:
TICK_MAX, 12_500_000, clocks per tick at normal rate (250 ms at 50 MHz); must be >= 2
TURBO_DIV, 16, turbo tick period = TICK_MAX/TURBO_DIV (integer division, result clamped to >= 1)
DOUT_W, 8, width of dIn/dOut
GPO_W, 6, width of GPO
IP_W, 8, width of IP
DEBOUNCE_CYC, 250_000, stable cycles required per button; used only with DEBOUNCE_EN

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
dIn  in  DOUT_W  data sampled into dOut
sample  in  1  async level; rising edge loads dIn into dOut
btns  in  3  async buttons: [0] mode advance, [1] run/pause toggle, [2] single-step
turbo  in  1  async level; 1 selects the turbo tick period
dOut  out  DOUT_W  display pattern
dValid  out  1  one-cycle pulse, coincident with each dOut update
GPO  out  GPO_W  general-purpose output pattern
debug  out  4  {state==RUN, mode[1:0], heartbeat}
IP  out  IP_W  update counter

Behaviour:
- Reset (async assert, sync release): dOut=0, dValid=0, GPO=0, IP=0, debug=0. Mode=COUNT_UP, state=PAUSE, tick counter=0, all sync flops=0. Reset mid-operation aborts everything immediately.
- sample, turbo and btns each pass through a 2-flop synchroniser. sample and btns then go through a rising-edge detector.
- Edge latency: the output effect appears exactly 3 clock edges after the first edge that samples the input high.
- Tick counter: limit L = turbo_sync ? TICK_MAX/TURBO_DIV : TICK_MAX. Counter increments each cycle. When count >= L-1: tick=1 for one cycle and count<=0. This >= compare covers turbo switching while count exceeds the new L.
- States: PAUSE and RUN.
  - btns[1] edge toggles the state.
  - In RUN, an update occurs on tick.
  - In PAUSE, an update occurs only on a btns[2] edge; ticks are ignored.
  - btns[2] in RUN is ignored.
- Modes (2-bit), advanced by a btns[0] edge: COUNT_UP -> COUNT_DOWN -> WALK -> ECHO -> COUNT_UP.
  - A mode change clears the tick counter.
  - A mode change does not itself update any output.
- Update actions:
  - All arithmetic is modulo 2^width.
  - IP <= IP+1 on every update.
  - COUNT_UP: dOut+1, GPO+1.
  - COUNT_DOWN: dOut-1, GPO-1.
  - WALK: dOut and GPO each rotate left by 1; a register that is 0 loads 1 instead.
  - ECHO: dOut <= dIn; GPO unchanged.
- Sample edge (any mode, any state): dOut <= dIn, dValid pulses, IP and GPO unchanged.
- Priority in the same cycle:
  - reset > sample > mode change > run/pause toggle > update.
  - An update coinciding with a sample or mode change is dropped; it is not deferred.
  - A toggle coinciding with a tick applies the new state from the next cycle; the tick uses the old state.
- dValid=1 only in the cycle following a dOut-changing update or sample. It also pulses in ECHO when dIn equals dOut.
- Heartbeat: toggles on every tick regardless of state.

Optional Feature:
- BOARD_TEST_DEBOUNCE_EN defined: each synchronised button must be stable for DEBOUNCE_CYC consecutive cycles before its debounced level changes. Edges are detected on the debounced level, adding DEBOUNCE_CYC cycles of latency. sample and turbo are not debounced.
- Undefined: no debounce logic; 3-edge latency as above.

Decomposition:
- Package board_test_pkg holds:
  - mode enum (COUNT_UP=0, COUNT_DOWN=1, WALK=2, ECHO=3)
  - state enum (PAUSE=0, RUN=1)
  - debug bit-index constants
- One sub-module, board_test_tick_gen: prescaler with turbo select and clear input. Outputs a one-cycle tick.

Test Plan:
(Use TICK_MAX=10, TURBO_DIV=2, defaults otherwise.)
- Reset release, pulse btns[1] -> state RUN, debug[3]=1. With turbo=0, dOut steps 1,2,3 exactly 10 cycles apart; dValid pulses each step; IP tracks dOut.
- turbo=1 while counter=7 -> counter wraps next cycle. Subsequent ticks every 5 cycles. dOut=0xFF then next update gives 0x00 (wrap).
- btns[0] twice (WALK) with dOut=0 and GPO=0 -> first update dOut=0x01, GPO=0x01. Then 0x02, 0x04 ... 0x80, then 0x01. GPO wraps from 0x20 to 0x01.
- PAUSE, ECHO, dIn=0xA5, btns[2] pulse -> dOut=0xA5, IP+1, one dValid pulse. With no step, ticks occur but outputs are unchanged.
- sample edge in the same cycle as a tick in COUNT_UP with dIn=0x3C -> dOut=0x3C, IP unchanged, no extra increment.
- Assert reset mid-run with dOut=0x42 -> all outputs 0 immediately, without waiting for a clock edge; state PAUSE, mode COUNT_UP after release.

Source files
------------

// File: rtl/board_test_pkg.sv
// Shared types and constants for the board bring-up pattern generator.
package board_test_pkg;

    typedef enum logic [1:0] {
        COUNT_UP   = 2'd0,
        COUNT_DOWN = 2'd1,
        WALK       = 2'd2,
        ECHO       = 2'd3
    } mode_t;

    typedef enum logic {
        PAUSE = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int unsigned DEBUG_W       = 4;
    localparam int unsigned DBG_HEARTBEAT = 0;
    localparam int unsigned DBG_MODE_LO   = 1;
    localparam int unsigned DBG_MODE_HI   = 2;
    localparam int unsigned DBG_RUN       = 3;

    localparam int unsigned BTN_W    = 3;
    localparam int unsigned BTN_MODE = 0;
    localparam int unsigned BTN_RUN  = 1;
    localparam int unsigned BTN_STEP = 2;

    function automatic mode_t next_mode(input mode_t m);
        return mode_t'(m + 2'd1);
    endfunction

endpackage

// File: rtl/board_test_tick_gen.sv
// Update-tick prescaler: normal or turbo period, cleared on demand.
module board_test_tick_gen #(
    parameter int unsigned TICK_MAX  = 12_500_000,
    parameter int unsigned TURBO_DIV = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic turbo,
    input  logic clear,
    output logic tick_c
);

    localparam int unsigned TURBO_RAW = TICK_MAX / TURBO_DIV;
    localparam int unsigned TURBO_MAX = (TURBO_RAW < 1) ? 1 : TURBO_RAW;
    localparam int unsigned CNT_W     = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;

    localparam logic [CNT_W-1:0] NORM_LAST  = CNT_W'(TICK_MAX - 1);
    localparam logic [CNT_W-1:0] TURBO_LAST = CNT_W'(TURBO_MAX - 1);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] last_c;

    // >= rather than == so a switch to the shorter period never overshoots
    assign last_c = turbo ? TURBO_LAST : NORM_LAST;
    assign tick_c = (count >= last_c);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || tick_c) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/board_test_gen.sv
// Board bring-up pattern generator driving the display outputs in place of the CPU.
// Define BOARD_TEST_DEBOUNCE_EN to debounce the synchronised buttons.
module board_test_gen
    import board_test_pkg::*;
#(
    parameter int unsigned TICK_MAX  = 12_500_000,
    parameter int unsigned TURBO_DIV = 16,
    parameter int unsigned DOUT_W    = 8,
    parameter int unsigned GPO_W     = 6,
    parameter int unsigned IP_W      = 8
`ifdef BOARD_TEST_DEBOUNCE_EN
    ,
    parameter int unsigned DEBOUNCE_CYC = 250_000
`endif
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [DOUT_W-1:0]   dIn,
    input  logic                sample,
    input  logic [BTN_W-1:0]    btns,
    input  logic                turbo,
    output logic [DOUT_W-1:0]   dOut,
    output logic                dValid,
    output logic [GPO_W-1:0]    GPO,
    output logic [DEBUG_W-1:0]  debug,
    output logic [IP_W-1:0]     IP
);

    logic             sample_meta, sample_sync, sample_prev;
    logic             turbo_meta, turbo_sync;
    logic [BTN_W-1:0] btns_meta, btns_sync, btns_level, btns_prev;

    logic             sample_rise_c;
    logic [BTN_W-1:0] btns_rise_c;
    logic             mode_go_c;
    logic             update_go_c;
    logic             tick_c;

    state_t            state, state_nxt;
    mode_t             mode, mode_nxt;
    logic [DOUT_W-1:0] dout_nxt, walk_dout_c;
    logic [GPO_W-1:0]  gpo_nxt, walk_gpo_c;
    logic [IP_W-1:0]   ip_nxt;
    logic              dvalid_nxt;
    logic              heartbeat, hb_nxt;

    // Two-flop synchronisers plus the previous-level flops for edge detection
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sample_meta <= 1'b0;
            sample_sync <= 1'b0;
            sample_prev <= 1'b0;
            turbo_meta  <= 1'b0;
            turbo_sync  <= 1'b0;
            btns_meta   <= '0;
            btns_sync   <= '0;
            btns_prev   <= '0;
        end else begin
            sample_meta <= sample;
            sample_sync <= sample_meta;
            sample_prev <= sample_sync;
            turbo_meta  <= turbo;
            turbo_sync  <= turbo_meta;
            btns_meta   <= btns;
            btns_sync   <= btns_meta;
            btns_prev   <= btns_level;
        end
    end

`ifdef BOARD_TEST_DEBOUNCE_EN
    localparam int unsigned DB_CYC = (DEBOUNCE_CYC < 1) ? 1 : DEBOUNCE_CYC;
    localparam int unsigned DB_W   = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYC - 1);

    logic [DB_W-1:0] db_cnt [BTN_W];

    // Level follows a button only after DB_CYC consecutive disagreeing cycles
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            btns_level <= '0;
            for (int i = 0; i < int'(BTN_W); i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(BTN_W); i++) begin
                if (btns_sync[i] == btns_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    btns_level[i] <= btns_sync[i];
                    db_cnt[i]     <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end
`else
    assign btns_level = btns_sync;
`endif

    assign sample_rise_c = sample_sync & ~sample_prev;
    assign btns_rise_c   = btns_level & ~btns_prev;

    // A sample edge outranks a mode change; either one drops a same-cycle update
    assign mode_go_c   = btns_rise_c[BTN_MODE] & ~sample_rise_c;
    assign update_go_c = (state == RUN) ? tick_c : btns_rise_c[BTN_STEP];

    board_test_tick_gen #(
        .TICK_MAX  (TICK_MAX),
        .TURBO_DIV (TURBO_DIV)
    ) u_tick_gen (
        .clock  (clock),
        .reset  (reset),
        .turbo  (turbo_sync),
        .clear  (mode_go_c),
        .tick_c (tick_c)
    );

    // Rotate left by one; an all-zero register seeds a single one
    assign walk_dout_c = (dOut == '0) ? DOUT_W'(1) : ((dOut << 1) | (dOut >> (DOUT_W - 1)));
    assign walk_gpo_c  = (GPO == '0)  ? GPO_W'(1)  : ((GPO << 1)  | (GPO >> (GPO_W - 1)));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= PAUSE;
            mode      <= COUNT_UP;
            dOut      <= '0;
            GPO       <= '0;
            IP        <= '0;
            dValid    <= 1'b0;
            heartbeat <= 1'b0;
        end else begin
            state     <= state_nxt;
            mode      <= mode_nxt;
            dOut      <= dout_nxt;
            GPO       <= gpo_nxt;
            IP        <= ip_nxt;
            dValid    <= dvalid_nxt;
            heartbeat <= hb_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        mode_nxt   = mode;
        dout_nxt   = dOut;
        gpo_nxt    = GPO;
        ip_nxt     = IP;
        dvalid_nxt = 1'b0;
        hb_nxt     = heartbeat ^ tick_c;

        if (sample_rise_c) begin
            dout_nxt   = dIn;
            dvalid_nxt = 1'b1;
        end else if (mode_go_c) begin
            mode_nxt = next_mode(mode);
        end else begin
            // Toggle lands next cycle; this cycle's update still sees the old state
            if (btns_rise_c[BTN_RUN]) begin
                state_nxt = (state == RUN) ? PAUSE : RUN;
            end
            if (update_go_c) begin
                ip_nxt     = IP + IP_W'(1);
                dvalid_nxt = 1'b1;
                case (mode)
                    COUNT_UP: begin
                        dout_nxt = dOut + DOUT_W'(1);
                        gpo_nxt  = GPO + GPO_W'(1);
                    end
                    COUNT_DOWN: begin
                        dout_nxt = dOut - DOUT_W'(1);
                        gpo_nxt  = GPO - GPO_W'(1);
                    end
                    WALK: begin
                        dout_nxt = walk_dout_c;
                        gpo_nxt  = walk_gpo_c;
                    end
                    ECHO: begin
                        dout_nxt = dIn;
                    end
                    default: begin
                        dout_nxt = dOut;
                    end
                endcase
            end
        end
    end

    assign debug[DBG_RUN]                 = (state == RUN);
    assign debug[DBG_MODE_HI:DBG_MODE_LO] = mode;
    assign debug[DBG_HEARTBEAT]           = heartbeat;

endmodule
